// File: rtl/lif_layer_pkg.sv
// Shared definitions for the LIF layer: default widths, FSM state type and
// a saturating add used by both the accumulator path and the membrane update.
package lif_layer_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 21;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Adds two sign-extended operands and clamps the result to a w-bit signed range (w <= 31).
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sum = a + b;
    hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo  = -(32'sd1 <<< (w - 1));
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/lif_layer_if.sv
// Input handshake and spike output bundle of the LIF layer.
interface lif_layer_if #(
  parameter int NUM_NEURONS = 8,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
);
  logic                     boot_mode;
  logic                     snn_tick;
  logic                     data_ready;
  logic                     din_ready;
  logic signed [DATA_W-1:0] din;
  logic [IDX_W-1:0]         din_idx;
  logic [NUM_NEURONS-1:0]   spike;
  logic                     spike_valid;
  logic                     busy;
  logic                     overrun;

  modport master (
    output boot_mode, snn_tick, data_ready, din, din_idx,
    input  din_ready, spike, spike_valid, busy, overrun
  );

  modport slave (
    input  boot_mode, snn_tick, data_ready, din, din_idx,
    output din_ready, spike, spike_valid, busy, overrun
  );
endinterface

// File: rtl/lif_neuron_update.sv
// Combinational leaky integrate-and-fire step for a single neuron:
// (acc, bias, vth, refract) -> (next membrane, fire, next refractory count).
module lif_neuron_update
  import lif_layer_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ACC_W         = DEF_ACC_W,
  parameter int SHIFT_VALUE   = 2,
  parameter int THRESHOLD     = 100,
  parameter int REFRACT_TICKS = 2,
  parameter int RW            = 2
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] bias,
  input  logic signed [ACC_W-1:0]  vth,
  input  logic [RW-1:0]            refract,
  output logic signed [ACC_W-1:0]  nv,
  output logic                     fire,
  output logic [RW-1:0]            refract_next
);

  localparam logic signed [ACC_W-1:0] THR_C = ACC_W'(THRESHOLD);

  logic signed [ACC_W+1:0] sum_s;
  logic signed [ACC_W-1:0] leak_s;

  // Two guard bits keep acc + bias - vth exact before the leak shift.
  always_comb begin
    sum_s  = (ACC_W+2)'(acc) + (ACC_W+2)'(bias) - (ACC_W+2)'(vth);
    leak_s = ACC_W'(sat_add(32'(vth), 32'(sum_s >>> SHIFT_VALUE), ACC_W));
    if (refract != {RW{1'b0}}) begin
      nv           = {ACC_W{1'b0}};
      fire         = 1'b0;
      refract_next = refract - RW'(1'b1);
    end else if (leak_s >= THR_C) begin
      nv           = {ACC_W{1'b0}};
      fire         = 1'b1;
      refract_next = RW'(REFRACT_TICKS);
    end else begin
      nv           = leak_s;
      fire         = 1'b0;
      refract_next = {RW{1'b0}};
    end
  end

endmodule

// File: rtl/lif_layer.sv
// Layer of NUM_NEURONS LIF neurons sharing one serial update datapath; inputs
// accumulate between ticks, each tick walks every neuron once and publishes the spike vector.
module lif_layer
  import lif_layer_pkg::*;
#(
  parameter int NUM_NEURONS   = 8,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ACC_W         = DEF_ACC_W,
  parameter int SHIFT_VALUE   = 2,
  parameter int THRESHOLD     = 100,
  parameter int REFRACT_TICKS = 2
) (
  input logic        sys_clk,
  input logic        rst_n,
  lif_layer_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam int RW    = (REFRACT_TICKS > 0) ? $clog2(REFRACT_TICKS + 1) : 1;

  logic signed [ACC_W-1:0]  acc_r     [NUM_NEURONS];
  logic signed [ACC_W-1:0]  vth_r     [NUM_NEURONS];
  logic signed [DATA_W-1:0] bias_r    [NUM_NEURONS];
  logic [RW-1:0]            refract_r [NUM_NEURONS];

  state_t                 state_r;
  logic [IDX_W-1:0]       idx_r;
  logic [NUM_NEURONS-1:0] shadow_r;
  logic [NUM_NEURONS-1:0] spike_r;
  logic                   spike_valid_r;
  logic                   busy_r;
  logic                   overrun_r;

  logic                    xfer_s;
  logic                    idx_ok_s;
  logic                    last_s;
  logic signed [ACC_W-1:0] acc_sum_s;
  logic signed [ACC_W-1:0] nv_s;
  logic                    fire_s;
  logic [RW-1:0]           refract_next_s;
  logic [NUM_NEURONS-1:0]  spike_next_s;

  lif_neuron_update #(
    .DATA_W        (DATA_W),
    .ACC_W         (ACC_W),
    .SHIFT_VALUE   (SHIFT_VALUE),
    .THRESHOLD     (THRESHOLD),
    .REFRACT_TICKS (REFRACT_TICKS),
    .RW            (RW)
  ) u_update (
    .acc          (acc_r[idx_r]),
    .bias         (bias_r[idx_r]),
    .vth          (vth_r[idx_r]),
    .refract      (refract_r[idx_r]),
    .nv           (nv_s),
    .fire         (fire_s),
    .refract_next (refract_next_s)
  );

  // Handshake decode, saturating accumulate and the spike vector including the last neuron.
  always_comb begin
    xfer_s               = bus.data_ready && !busy_r;
    idx_ok_s             = (32'(bus.din_idx) < NUM_NEURONS);
    last_s               = (32'(idx_r) == NUM_NEURONS - 1);
    acc_sum_s            = ACC_W'(sat_add(32'(acc_r[bus.din_idx]), 32'(bus.din), ACC_W));
    spike_next_s         = shadow_r;
    spike_next_s[idx_r]  = fire_s;
  end

  // Update sequencer and all externally visible status registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      idx_r         <= {IDX_W{1'b0}};
      shadow_r      <= {NUM_NEURONS{1'b0}};
      spike_r       <= {NUM_NEURONS{1'b0}};
      spike_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      spike_valid_r <= 1'b0;
      if (bus.snn_tick && busy_r) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (bus.snn_tick && !bus.boot_mode) begin
            state_r  <= ST_UPDATE;
            idx_r    <= {IDX_W{1'b0}};
            shadow_r <= {NUM_NEURONS{1'b0}};
            busy_r   <= 1'b1;
          end
        end
        ST_UPDATE: begin
          shadow_r[idx_r] <= fire_s;
          // Publish on the last neuron so spike_valid is visible during DONE.
          if (last_s) begin
            spike_r       <= spike_next_s;
            spike_valid_r <= 1'b1;
            busy_r        <= 1'b0;
            state_r       <= ST_DONE;
          end else begin
            idx_r <= idx_r + IDX_W'(1'b1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Per-neuron state: bias/acc writes from the input port, membrane writes from the updater.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        acc_r[i]     <= {ACC_W{1'b0}};
        vth_r[i]     <= {ACC_W{1'b0}};
        bias_r[i]    <= {DATA_W{1'b0}};
        refract_r[i] <= {RW{1'b0}};
      end
    end else if (state_r == ST_UPDATE) begin
      acc_r[idx_r]     <= {ACC_W{1'b0}};
      vth_r[idx_r]     <= nv_s;
      refract_r[idx_r] <= refract_next_s;
    end else if (xfer_s && idx_ok_s) begin
      if (bus.boot_mode) begin
        bias_r[bus.din_idx] <= bus.din;
      end else begin
        acc_r[bus.din_idx] <= acc_sum_s;
      end
    end
  end

  assign bus.din_ready   = !busy_r;
  assign bus.spike       = spike_r;
  assign bus.spike_valid = spike_valid_r;
  assign bus.busy        = busy_r;
  assign bus.overrun     = overrun_r;

endmodule

// File: tb/tb_lif_layer.sv
// Scoreboard bench for lif_layer: an arithmetic reference model predicts each
// tick's spike vector and publish cycle; a negedge monitor checks every output.
module tb_lif_layer;

  localparam int N       = 8;
  localparam int DATA_W  = 16;
  localparam int ACC_W   = 21;
  localparam int SHIFT   = 2;
  localparam int THR     = 100;
  localparam int REFR    = 2;
  localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
  localparam int ACC_MIN = -(1 << (ACC_W - 1));

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;

  lif_layer_if #(.NUM_NEURONS(N), .DATA_W(DATA_W), .IDX_W(3)) bus ();

  lif_layer #(
    .NUM_NEURONS(N), .DATA_W(DATA_W), .ACC_W(ACC_W),
    .SHIFT_VALUE(SHIFT), .THRESHOLD(THR), .REFRACT_TICKS(REFR)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int acc_m  [N];
  int vth_m  [N];
  int bias_m [N];
  int refr_m [N];

  logic [N-1:0] exp_spk_q [$];
  int           exp_cyc_q [$];
  logic [N-1:0] last_spike = '0;
  logic [N-1:0] mon_e;
  int           mon_c;

  function automatic int clip(int v);
    if (v > ACC_MAX) return ACC_MAX;
    if (v < ACC_MIN) return ACC_MIN;
    return v;
  endfunction

  // Floor division by 2^SHIFT, i.e. the arithmetic right shift of the rule.
  function automatic int floor_div(int v);
    int d;
    int m;
    d = 1 << SHIFT;
    m = ((v % d) + d) % d;
    return (v - m) / d;
  endfunction

  function automatic logic [N-1:0] model_update();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (refr_m[i] != 0) begin
        refr_m[i] = refr_m[i] - 1;
        vth_m[i]  = 0;
      end else begin
        int nv;
        nv = clip(vth_m[i] + floor_div(acc_m[i] + bias_m[i] - vth_m[i]));
        if (nv >= THR) begin
          v[i]      = 1'b1;
          vth_m[i]  = 0;
          refr_m[i] = REFR;
        end else begin
          vth_m[i] = nv;
        end
      end
      acc_m[i] = 0;
    end
    return v;
  endfunction

  task automatic apply_xfer(int idx, int val, bit boot);
    if (idx < N) begin
      if (boot) bias_m[idx] = val;
      else      acc_m[idx]  = clip(acc_m[idx] + val);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic send(int idx, int val, bit boot);
    bus.boot_mode  = boot;
    bus.din        = 16'(val);
    bus.din_idx    = 3'(idx);
    bus.data_ready = 1'b1;
    for (int w = 0; w < 50 && !bus.din_ready; w++) step();
    check("send_din_ready", int'(bus.din_ready), 1);
    if (bus.din_ready) apply_xfer(idx, val, boot);
    step();
    bus.data_ready = 1'b0;
    bus.boot_mode  = 1'b0;
  endtask

  task automatic tick(bit fold, int idx, int val);
    if (fold) begin
      bus.boot_mode  = 1'b0;
      bus.din        = 16'(val);
      bus.din_idx    = 3'(idx);
      bus.data_ready = 1'b1;
      check("fold_din_ready", int'(bus.din_ready), 1);
      apply_xfer(idx, val, 1'b0);
    end
    bus.snn_tick = 1'b1;
    exp_spk_q.push_back(model_update());
    exp_cyc_q.push_back(cyc + N + 1);
    step();
    bus.snn_tick   = 1'b0;
    bus.data_ready = 1'b0;
    repeat (N + 2) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_spk_q.delete();
    exp_cyc_q.delete();
    last_spike = '0;
    for (int i = 0; i < N; i++) begin
      acc_m[i] = 0; vth_m[i] = 0; bias_m[i] = 0; refr_m[i] = 0;
    end
    check("rst_spike", int'(bus.spike), 0);
    check("rst_spike_valid", int'(bus.spike_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    check("rst_din_ready", int'(bus.din_ready), 1);
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Monitor: every published vector must match the oldest prediction at the predicted cycle.
  always @(negedge sys_clk) begin
    if (rst_n) begin
      checks++;
      if (bus.spike_valid) begin
        if (exp_spk_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_spike_valid: spike=%b with nothing pending", bus.spike);
        end else begin
          mon_e = exp_spk_q.pop_front();
          mon_c = exp_cyc_q.pop_front();
          if (bus.spike !== mon_e) begin
            errors++;
            $display("FAIL spike_vector: got %b expected %b", bus.spike, mon_e);
          end
          checks++;
          if (cyc != mon_c) begin
            errors++;
            $display("FAIL spike_latency: got cycle %0d expected %0d", cyc, mon_c);
          end
          last_spike = mon_e;
        end
      end else if (bus.spike !== last_spike) begin
        errors++;
        $display("FAIL spike_hold: got %b expected %b", bus.spike, last_spike);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int n_send;
    int r;
    bus.boot_mode  = 1'b0;
    bus.snn_tick   = 1'b0;
    bus.data_ready = 1'b0;
    bus.din        = '0;
    bus.din_idx    = '0;

    do_reset();
    tick(1'b0, 0, 0);

    // Reset while an update is in flight: nothing may be published.
    send(4, 500, 1'b0);
    bus.snn_tick = 1'b1;
    exp_spk_q.push_back(model_update());
    exp_cyc_q.push_back(cyc + N + 1);
    step();
    bus.snn_tick = 1'b0;
    repeat (3) step();
    check("busy_mid_update", int'(bus.busy), 1);
    do_reset();
    tick(1'b0, 0, 0);

    // Threshold boundary (400 -> exactly 100 fires, 399 does not), then leak.
    send(3, 400, 1'b0);
    send(5, 399, 1'b0);
    tick(1'b0, 0, 0);
    send(0, 40, 1'b0);
    tick(1'b0, 0, 0);
    tick(1'b0, 0, 0);
    send(0, 379, 1'b0);
    tick(1'b0, 0, 0);

    // Refractory window: 400 each tick while silenced, fires again on the third.
    send(0, 400, 1'b0);
    tick(1'b0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      send(0, 400, 1'b0);
      tick(1'b0, 0, 0);
    end

    // Bias written in boot mode; a tick in boot mode is ignored.
    send(2, 120, 1'b1);
    bus.boot_mode = 1'b1;
    bus.snn_tick  = 1'b1;
    step();
    bus.snn_tick  = 1'b0;
    check("boot_tick_busy", int'(bus.busy), 0);
    bus.boot_mode = 1'b0;
    repeat (N + 2) step();
    tick(1'b0, 0, 0);

    // Saturation both ways, and a transfer folded into the tick cycle.
    for (int k = 0; k < 40; k++) send(1, 32767, 1'b0);
    for (int k = 0; k < 40; k++) send(6, -32768, 1'b0);
    tick(1'b1, 7, 300);
    tick(1'b0, 0, 0);

    // Overrun: second tick three cycles in; input held off until DONE.
    check("overrun_before", int'(bus.overrun), 0);
    bus.snn_tick = 1'b1;
    exp_spk_q.push_back(model_update());
    exp_cyc_q.push_back(cyc + N + 1);
    step();
    bus.snn_tick = 1'b0;
    step();
    step();
    bus.snn_tick = 1'b1;
    step();
    bus.snn_tick = 1'b0;
    check("overrun_busy", int'(bus.busy), 1);
    check("overrun_set", int'(bus.overrun), 1);
    check("din_ready_while_busy", int'(bus.din_ready), 0);
    send(2, 450, 1'b0);
    repeat (2) step();
    tick(1'b0, 0, 0);

    // Randomized traffic against the model.
    for (int round = 0; round < 40; round++) begin
      n_send = $urandom_range(0, 6);
      for (int k = 0; k < n_send; k++) begin
        r = $urandom_range(0, 9);
        if (r < 6)      send($urandom_range(0, N - 1), int'($urandom_range(0, 700)) - 200, 1'b0);
        else if (r < 8) send($urandom_range(0, N - 1), int'($urandom_range(0, 65535)) - 32768, 1'b0);
        else            send($urandom_range(0, N - 1), int'($urandom_range(0, 300)) - 150, 1'b1);
      end
      if ($urandom_range(0, 3) == 0) tick(1'b1, $urandom_range(0, N - 1), int'($urandom_range(0, 600)));
      else                           tick(1'b0, 0, 0);
    end

    check("overrun_sticky", int'(bus.overrun), 1);
    check("pending_expectations", exp_spk_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
